// File: rtl/alu_exec_sequencer.sv
// Multi-cycle execute sequencer wrapped around the combinational 16-bit ALU.
// Holds an 8-entry register file, issues operands to the ALU and retires results.
module alu_exec_sequencer #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [3:0]        alu_func,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zf,
    output logic              zf,
    output logic              done,
    output logic              err,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] OP_LDI = 4'h8;

    state_t            state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] rf_q [8];
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [3:0]        func_q, func_d;
    logic              zf_q, zf_d;
    logic              err_q, err_d;

    logic              rf_we;
    logic [2:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic [3:0]        ir_op;
    logic [2:0]        ir_rd, ir_rs1, ir_rs2;
    logic [8:0]        ir_imm9;
    logic              is_alu, is_ldi;

    assign ir_op   = ir_q[15:12];
    assign ir_rd   = ir_q[11:9];
    assign ir_rs1  = ir_q[8:6];
    assign ir_rs2  = ir_q[5:3];
    assign ir_imm9 = ir_q[8:0];
    assign is_alu  = ~ir_op[3];
    assign is_ldi  = (ir_op == OP_LDI);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d  = state_q;
        ir_d     = ir_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        func_d   = func_q;
        zf_d     = zf_q;
        err_d    = err_q;
        rf_we    = 1'b0;
        rf_waddr = ir_rd;
        rf_wdata = alu_result;

        unique case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    err_d   = 1'b0;
                    state_d = READ;
                end
            end
            READ: begin
                // Operands are captured here, before any EXEC writeback, so rd aliasing rs uses old data.
                if (is_alu) begin
                    op1_d   = rf_q[ir_rs1];
                    op2_d   = rf_q[ir_rs2];
                    func_d  = ir_op;
                    state_d = EXEC;
                end else if (is_ldi) begin
                    rf_we    = 1'b1;
                    rf_wdata = DATA_W'(ir_imm9);
                    state_d  = DONE;
                end else begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            EXEC: begin
                rf_we    = 1'b1;
                rf_wdata = alu_result;
                zf_d     = alu_zf;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ir_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            func_q  <= '0;
            zf_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            func_q  <= func_d;
            zf_q    <= zf_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the register file is small and architecturally zero after reset, so it is built from
    // resettable flops rather than an inferred RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign done        = (state_q == DONE);
    assign err         = (state_q == DONE) & err_q;
    assign alu_op1     = op1_q;
    assign alu_op2     = op2_q;
    assign alu_func    = func_q;
    assign zf          = zf_q;
    assign dbg_data    = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Self-checking bench for alu_exec_sequencer: a behavioural ALU drives the result
// inputs, and a scoreboard of expected register-file snapshots is checked at every retire.
module tb_alu_exec_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic [15:0] alu_op1, alu_op2, alu_result;
    logic [3:0]  alu_func;
    logic        alu_zf;
    logic        zf, done, err;
    logic [2:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    alu_exec_sequencer #(.DATA_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_func    (alu_func),
        .alu_result  (alu_result),
        .alu_zf      (alu_zf),
        .zf          (zf),
        .done        (done),
        .err         (err),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #10 clk = ~clk;

    // Behavioural stand-in for the downstream ALU.
    function automatic logic [15:0] alu_f(logic [15:0] a, logic [15:0] b, logic [3:0] f);
        case (f[2:0])
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return a << 1;
            default: return a >> 1;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_f(alu_op1, alu_op2, alu_func);
        alu_zf     = (alu_result == 16'h0);
    end

    typedef struct packed {
        logic [31:0]      done_cyc;
        logic             err;
        logic             zf;
        logic [7:0][15:0] rf;
    } exp_t;

    exp_t             sb[$];
    logic [7:0][15:0] model_rf = '0;
    logic             model_zf = 1'b0;
    int               n_cmp = 0;
    int               n_bad = 0;
    int               cyc = 0;
    int               n_issued = 0;
    int               n_done = 0;
    int               sweep_cnt = 0;
    logic             sweep_req = 1'b0;
    logic             busy = 1'b0;
    logic             prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reads all eight registers through the debug port; only the monitor calls this.
    task automatic sweep(logic [7:0][15:0] erf, logic ezf);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check($sformatf("rf[%0d]", i), 32'(dbg_data), 32'(erf[i]));
        end
        check("zf", 32'(zf), 32'(ezf));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy      = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (busy) check("ready_low_while_busy", 32'(instr_ready), 32'd0);
            if (err) check("err_with_done", 32'(done), 32'd1);
            if (done) begin
                check("done_single_cycle", 32'(prev_done), 32'd0);
                n_done++;
                busy = 1'b0;
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.done_cyc);
                    check("err", 32'(err), 32'(e.err));
                    sweep(e.rf, e.zf);
                end
            end else if (sweep_req) begin
                sweep(model_rf, model_zf);
                sweep_cnt++;
            end
            if (instr_valid && instr_ready) busy = 1'b1;
            prev_done = done;
        end
    end

    function automatic logic [15:0] ldi(int rd, int imm);
        return {4'h8, 3'(rd), 9'(imm)};
    endfunction

    function automatic logic [15:0] rop(int op, int rd, int rs1, int rs2);
        return {4'(op), 3'(rd), 3'(rs1), 3'(rs2), 3'b000};
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic issue(logic [15:0] w, bit keep, output int acc_cyc);
        exp_t        e;
        int          n;
        logic [3:0]  op;
        logic [15:0] r;
        n           = 0;
        instr       = w;
        instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!instr_ready) begin
            check("issue_timeout", 32'(instr_ready), 32'd1);
            instr_valid = 1'b0;
            acc_cyc     = -1;
            return;
        end
        acc_cyc = cyc;
        op      = w[15:12];
        e.err   = 1'b0;
        if (op < 4'h8) begin
            r                  = alu_f(model_rf[w[8:6]], model_rf[w[5:3]], op);
            model_rf[w[11:9]]  = r;
            model_zf           = (r == 16'h0);
        end else if (op == 4'h8) begin
            model_rf[w[11:9]] = {7'b0, w[8:0]};
        end else begin
            e.err = 1'b1;
        end
        e.rf       = model_rf;
        e.zf       = model_zf;
        e.done_cyc = 32'(acc_cyc + ((op < 4'h8) ? 3 : 2));
        sb.push_back(e);
        n_issued++;
        @(posedge clk);
        #1;
        if (!keep) instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !instr_ready) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_sweep();
        int s;
        int n;
        s         = sweep_cnt;
        n         = 0;
        sweep_req = 1'b1;
        while (sweep_cnt == s && n < 5) begin
            @(posedge clk);
            #1;
            n++;
        end
        sweep_req = 1'b0;
        check("sweep_timeout", 32'(sweep_cnt != s), 32'd1);
    endtask

    initial begin
        int a, a_ill, a_ldi, d0, i0, rsel;
        logic [15:0] w;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_zf", 32'(zf), 32'd0);
        check("rst_op1", 32'(alu_op1), 32'd0);
        check("rst_op2", 32'(alu_op2), 32'd0);
        check("rst_func", 32'(alu_func), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_sweep();

        // LDI, LDI, ADD
        d0 = n_done;
        issue(ldi(1, 5), 1'b0, a);
        issue(ldi(2, 10), 1'b0, a);
        issue(rop(0, 3, 1, 2), 1'b0, a);
        wait_idle();
        check("add_r3_value", 32'(model_rf[3]), 32'd15);
        check("three_dones", n_done - d0, 32'd3);

        // SUB nonzero then SUB to zero
        issue(ldi(4, 12), 1'b0, a);
        issue(ldi(5, 6), 1'b0, a);
        issue(rop(1, 6, 4, 5), 1'b0, a);
        issue(rop(1, 7, 5, 5), 1'b0, a);
        wait_idle();

        // Aliased ADD r1 <- r1 + r1
        issue(ldi(1, 9'h1FF), 1'b0, a);
        issue(rop(0, 1, 1, 1), 1'b0, a);
        @(posedge clk);
        #1;
        check("exec_op1", 32'(alu_op1), 32'h01FF);
        check("exec_op2", 32'(alu_op2), 32'h01FF);
        check("exec_func", 32'(alu_func), 32'h0);
        wait_idle();

        // Illegal word followed back-to-back by LDI with valid held high
        issue(16'hA123, 1'b1, a_ill);
        issue(ldi(2, 7), 1'b0, a_ldi);
        check("illegal_to_ldi_gap", a_ldi - a_ill, 32'd3);
        wait_idle();

        // Reset during EXEC
        issue(ldi(1, 1), 1'b0, a);
        issue(ldi(2, 2), 1'b0, a);
        issue(rop(0, 3, 1, 2), 1'b0, a);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        d0    = n_done;
        sb.delete();
        model_rf = '0;
        model_zf = 1'b0;
        #1;
        check("ready_in_reset", 32'(instr_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no_done_after_abort", n_done, d0);
        check("ready_after_abort", 32'(instr_ready), 32'd1);
        do_sweep();

        // Random mixed stream
        d0 = n_done;
        i0 = n_issued;
        for (int k = 0; k < 200; k++) begin
            rsel = int'($urandom_range(0, 9));
            if (rsel < 4)
                w = ldi(int'($urandom_range(0, 7)), int'($urandom_range(0, 511)));
            else if (rsel < 9)
                w = rop(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                        int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            else
                w = {4'(int'($urandom_range(9, 15))), 12'($urandom)};
            issue(w, 1'($urandom_range(0, 1)), a);
        end
        instr_valid = 1'b0;
        wait_idle();
        check("accepted_vs_done", n_done - d0, n_issued - i0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
